line_dram: RTL and testbench

LINE_DRAM -- requirements
Module: line_dram

---
 rtl/cache_pkg.sv | 20 ++
 rtl/line_dram_array.sv | 41 ++++
 rtl/line_dram.sv | 154 +++++++++++++++
 tb/tb_line_dram.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the cache-side line DRAM: LSU operation codes, DRAM
// controller states and the fill tag used to pattern memory at reset.
package cache_pkg;

    typedef enum logic {
        LW = 1'b0,
        SW = 1'b1
    } lsu_ops;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BURST = 3'd2,
        WR_BURST = 3'd3,
        WR_RESP  = 3'd4
    } dram_state_e;

    localparam logic [15:0] DRAM_FILL_TAG = 16'hDEAD;

endpackage

// File: rtl/line_dram_array.sv
// Word storage for line_dram: async-reset fill pattern (tag in the upper
// bits, word index in the low 16), one combinational read port, byte-strobed write.
module dram_array
    import cache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_strb,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int FILL_REPS = (DATA_W - 16) / 16;
    localparam int NBYTES    = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {{FILL_REPS{DRAM_FILL_TAG}}, 16'(i)};
            end
        end else if (i_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_strb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/line_dram.sv
// Line-burst DRAM model for the cache controller: critical-word-first line
// reads and writes. Define LINE_DRAM_WSTRB_EN to add per-byte write strobes.
module line_dram
    import cache_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int BURST_LEN  = 4,
    parameter int RD_LATENCY = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_req,
    input  lsu_ops              lsu_operator,
    input  logic [31:0]         address,
    output logic                mem_ready,
    input  logic                wr_valid,
    input  logic [DATA_W-1:0]   write_data,
`ifdef LINE_DRAM_WSTRB_EN
    input  logic [DATA_W/8-1:0] wr_strb,
`endif
    output logic                rd_valid,
    output logic                rd_last,
    output logic [DATA_W-1:0]   dram_data_out,
    output logic                wr_done,
    output dram_state_e         o_dbg_state
);

    localparam int AW    = $clog2(DEPTH);
    localparam int BCW   = $clog2(BURST_LEN) + 1;
    localparam int LAT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
    localparam logic [BCW-1:0] BEAT_END  = BCW'(BURST_LEN);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);

    dram_state_e         r_state;
    logic [AW-1:0]       r_idx;
    logic [BCW-1:0]      r_beat;
    logic [LAT_W-1:0]    r_lat;
    logic [DATA_W-1:0]   r_data;

    logic [AW-1:0]       w_raddr;
    logic [AW-1:0]       w_waddr;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_we;
    logic                w_unused_addr;

    // Beat k of a line starts at the requested word and wraps within the line.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] idx,
                                                input logic [BCW-1:0] k);
        logic [AW-1:0] line_mask;
        line_mask = AW'(BURST_LEN - 1);
        return (idx & ~line_mask) | ((idx + AW'(k)) & line_mask);
    endfunction

`ifdef LINE_DRAM_WSTRB_EN
    assign w_strb = wr_strb;
`else
    assign w_strb = '1;
`endif

    assign w_unused_addr = &{1'b0, address[31:AW]};

    assign mem_ready     = (r_state == IDLE);
    assign rd_valid      = (r_state == RD_BURST);
    assign rd_last       = (r_state == RD_BURST) && (r_beat == BEAT_END);
    assign wr_done       = (r_state == WR_RESP);
    assign dram_data_out = r_data;
    assign o_dbg_state   = r_state;

    // In IDLE the read port looks at the live address so a 1-cycle latency can launch beat 0.
    assign w_raddr = (r_state == IDLE) ? address[AW-1:0] : beat_addr(r_idx, r_beat);
    assign w_waddr = beat_addr(r_idx, r_beat);
    assign w_we    = (r_state == WR_BURST) && wr_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_beat  <= '0;
            r_lat   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_req) begin
                        r_idx  <= address[AW-1:0];
                        r_beat <= '0;
                        if (lsu_operator == LW) begin
                            if (RD_LATENCY == 1) begin
                                r_data  <= w_rdata;
                                r_beat  <= BCW'(1);
                                r_state <= RD_BURST;
                            end else begin
                                r_lat   <= LAT_W'(RD_LATENCY - 2);
                                r_state <= RD_WAIT;
                            end
                        end else begin
                            r_state <= WR_BURST;
                        end
                    end
                end
                RD_WAIT: begin
                    if (r_lat == '0) begin
                        r_data  <= w_rdata;
                        r_beat  <= r_beat + BCW'(1);
                        r_state <= RD_BURST;
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                RD_BURST: begin
                    // r_beat counts beats already presented; the next one is fetched ahead.
                    if (r_beat == BEAT_END) begin
                        r_state <= IDLE;
                    end else begin
                        r_data <= w_rdata;
                        r_beat <= r_beat + BCW'(1);
                    end
                end
                WR_BURST: begin
                    if (wr_valid) begin
                        if (r_beat == BEAT_LAST) begin
                            r_state <= WR_RESP;
                        end
                        r_beat <= r_beat + BCW'(1);
                    end
                end
                WR_RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    dram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (write_data),
        .i_strb  (w_strb),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_line_dram.sv
// Directed bench for line_dram: a line-level memory model predicts every
// read beat, wr_done pulse and mem_ready cycle; literal vectors pin the model.
module tb_line_dram;
    import cache_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int BL    = 4;
    localparam int RL    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req = 1'b0;
    lsu_ops      lsu_operator = LW;
    logic [31:0] address = '0;
    logic        wr_valid = 1'b0;
    logic [31:0] write_data = '0;
`ifdef LINE_DRAM_WSTRB_EN
    logic [3:0]  wr_strb = 4'hF;
`endif
    logic        mem_ready;
    logic        rd_valid;
    logic        rd_last;
    logic [31:0] dram_data_out;
    logic        wr_done;
    dram_state_e dbg_state;

    always #5 clk = ~clk;

    line_dram #(
        .DATA_W     (DW),
        .DEPTH      (DEPTH),
        .BURST_LEN  (BL),
        .RD_LATENCY (RL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req       (mem_req),
        .lsu_operator  (lsu_operator),
        .address       (address),
        .mem_ready     (mem_ready),
        .wr_valid      (wr_valid),
        .write_data    (write_data),
`ifdef LINE_DRAM_WSTRB_EN
        .wr_strb       (wr_strb),
`endif
        .rd_valid      (rd_valid),
        .rd_last       (rd_last),
        .dram_data_out (dram_data_out),
        .wr_done       (wr_done),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- cycle counter and scoreboard state
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_hold;
    int          exp_free;
    int          exp_wd;
    logic [31:0] obs_d[$];
    int          obs_c[$];
    logic        obs_l[$];
    int          obs_wd[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fill(input int i);
        return {16'hDEAD, 16'(i)};
    endfunction

    function automatic int beat_idx(input int idx, input int k);
        return (idx / BL) * BL + (idx + k) % BL;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = fill(i);
        exp_q.delete();
        exp_hold = '0;
        exp_free = 0;
        exp_wd   = -1;
    endtask

    task automatic model_accept(input lsu_ops op, input logic [31:0] a, input int t);
        int idx;
        idx = int'(a % DEPTH);
        if (op == LW) begin
            for (int k = 0; k < BL; k++) begin
                exp_q.push_back('{t + RL + k, model_mem[beat_idx(idx, k)], (k == BL - 1)});
            end
            exp_free = t + RL + BL;
        end else begin
            exp_free = 32'h7fff_ffff;
        end
    endtask

    // ---------------- per-cycle compare
    always @(negedge clk) begin
        bit    exp_v;
        beat_t b;
        if (rd_valid && !rst) begin
            obs_d.push_back(dram_data_out);
            obs_c.push_back(cyc);
            obs_l.push_back(rd_last);
        end
        if (wr_done && !rst) obs_wd.push_back(cyc);
        if (rst) begin
            check("rst_rd_valid", 64'(rd_valid), 64'd0);
            check("rst_rd_last", 64'(rd_last), 64'd0);
            check("rst_wr_done", 64'(wr_done), 64'd0);
            check("rst_data", 64'(dram_data_out), 64'd0);
            check("rst_mem_ready", 64'(mem_ready), 64'd1);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("beat_missed_at", 64'(cyc), 64'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("rd_valid", 64'(rd_valid), 64'(exp_v));
            if (exp_v) begin
                b = exp_q.pop_front();
                check("rd_data", 64'(dram_data_out), 64'(b.d));
                check("rd_last", 64'(rd_last), 64'(b.last));
                exp_hold = b.d;
            end else begin
                check("data_hold", 64'(dram_data_out), 64'(exp_hold));
                check("rd_last_idle", 64'(rd_last), 64'd0);
            end
            check("wr_done", 64'(wr_done), 64'(cyc == exp_wd));
            check("mem_ready", 64'(mem_ready), 64'(cyc >= exp_free));
        end
    end

    // ---------------- driver tasks (called at #1 after a rising edge)
    task automatic do_req(input lsu_ops op, input logic [31:0] a, input bit keep, output int t);
        mem_req      = 1'b1;
        lsu_operator = op;
        address      = a;
        t = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (mem_ready) begin
                t = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (t < 0) begin
            check("req_timeout", 64'd0, 64'd1);
        end else begin
            model_accept(op, a, t);
        end
        if (!keep) mem_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (mem_ready && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0][31:0] d,
                            input int stall_after, output int t_last);
        int          t;
        int          idx;
        int          wi;
        logic [31:0] mask;
        do_req(SW, a, 1'b0, t);
        idx = int'(a % DEPTH);
        t_last = -1;
        for (int k = 0; k < BL; k++) begin
            wr_valid   = 1'b1;
            write_data = d[k];
`ifdef LINE_DRAM_WSTRB_EN
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{wr_strb[b]}};
`else
            mask = '1;
`endif
            wi = beat_idx(idx, k);
            model_mem[wi] = (model_mem[wi] & ~mask) | (d[k] & mask);
            if (k == BL - 1) begin
                exp_wd   = cyc + 1;
                exp_free = cyc + 2;
                t_last   = cyc;
            end
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
            if (k == stall_after) begin
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_idle();
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [3:0][31:0] e);
        int n0;
        int t;
        n0 = obs_d.size();
        do_req(LW, a, 1'b0, t);
        wait_idle();
        check({name, "_beats"}, 64'(obs_d.size() - n0), 64'd4);
        if (obs_d.size() >= n0 + 4) begin
            for (int k = 0; k < 4; k++) check({name, "_word"}, 64'(obs_d[n0 + k]), 64'(e[k]));
            check({name, "_first_cyc"}, 64'(obs_c[n0]), 64'(t + 3));
            check({name, "_last_cyc"}, 64'(obs_c[n0 + 3]), 64'(t + 6));
            check({name, "_last_flag"}, 64'(obs_l[n0 + 3]), 64'd1);
            check({name, "_early_last"}, 64'(obs_l[n0]), 64'd0);
        end
    endtask

    // ---------------- directed sequence
    initial begin
        int t1;
        int t2;
        int tl;
        int n0;
        int nw0;

        model_reset();
        #1 rst = 1'b1;
        #1;
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        check("reset_ready", 64'(mem_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // critical-word-first line reads
        read_check("lw_08", 32'h08, {32'hDEAD000B, 32'hDEAD000A, 32'hDEAD0009, 32'hDEAD0008});
        read_check("lw_40a", 32'h40A, {32'hDEAD0009, 32'hDEAD0008, 32'hDEAD000B, 32'hDEAD000A});
        read_check("lw_3fe", 32'h3FE, {32'hDEAD03FD, 32'hDEAD03FC, 32'hDEAD03FF, 32'hDEAD03FE});

        // stalled write burst, then read it back
        nw0 = obs_wd.size();
        do_write(32'h10, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1, tl);
        check("sw_done_pulses", 64'(obs_wd.size() - nw0), 64'd1);
        if (obs_wd.size() > nw0) check("sw_done_cyc", 64'(obs_wd[nw0]), 64'(tl + 1));
        read_check("lw_10", 32'h10, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});

        // request held through a read: next accept is the cycle after rd_last
        n0 = obs_d.size();
        do_req(LW, 32'h08, 1'b1, t1);
        do_req(LW, 32'h0C, 1'b0, t2);
        check("hold_accept_cyc", 64'(t2), 64'(t1 + 7));
        wait_idle();
        check("hold_beats", 64'(obs_d.size() - n0), 64'd8);
        if (obs_d.size() >= n0 + 8) begin
            check("hold_first_word", 64'(obs_d[n0]), 64'h0000_0000_DEAD0008);
            check("hold_second_word", 64'(obs_d[n0 + 4]), 64'h0000_0000_DEAD000C);
        end

        // reset after read beat 2
        n0 = obs_d.size();
        do_req(LW, 32'h08, 1'b0, t1);
        while (cyc < t1 + 5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_rd_valid", 64'(rd_valid), 64'd0);
        check("midrst_beats_seen", 64'(obs_d.size() - n0), 64'd2);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("postrst_ready", 64'(mem_ready), 64'd1);
        @(posedge clk);
        #1;
        read_check("lw_10_restored", 32'h10, {32'hDEAD0013, 32'hDEAD0012, 32'hDEAD0011, 32'hDEAD0010});

`ifdef LINE_DRAM_WSTRB_EN
        wr_strb = 4'b0011;
        do_write(32'h20, {4{32'h12345678}}, -1, tl);
        wr_strb = 4'hF;
        read_check("lw_20_strb", 32'h20, {4{32'hDEAD5678}});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
